// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
// Optional feature macro used by pc_gen: PC_RVC_EN (16-bit compressed instructions).
package pc_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0100;

    localparam int unsigned ILEN_BYTES_RVC = 2;
    localparam int unsigned ILEN_BYTES_STD = 4;

    // With compressed support only halfword alignment matters.
    function automatic logic target_misaligned(input logic [1:0] lo, input logic rvc);
        return rvc ? lo[0] : (lo != 2'b00);
    endfunction

endpackage

// File: rtl/pc_adder.sv
// XLEN-wide unsigned adder; wraps silently modulo 2^XLEN.
// Used for the sequential PC and the JAL/JALR link value.
module pc_adder #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential/redirect next-PC, stall, EBREAK halt/resume,
// misaligned-redirect trap and retired counter. Define PC_RVC_EN for 16-bit instructions.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR),
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             pc_src,
    input  logic [XLEN-1:0]  pc_target,
    input  logic             ebreak,
    input  logic             resume,
`ifdef PC_RVC_EN
    input  logic             is_compressed,
`endif
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus_4,
    output logic             halted,
    output logic             trap,
    output logic [XLEN-1:0]  trap_addr,
    output logic [CNT_W-1:0] retired
);

    pc_state_e       state;
    logic [XLEN-1:0] incr;
    logic            misaligned;

`ifdef PC_RVC_EN
    assign incr       = is_compressed ? XLEN'(ILEN_BYTES_RVC) : XLEN'(ILEN_BYTES_STD);
    assign misaligned = target_misaligned(pc_target[1:0], 1'b1);
`else
    assign incr       = XLEN'(ILEN_BYTES_STD);
    assign misaligned = target_misaligned(pc_target[1:0], 1'b0);
`endif

    pc_adder #(.XLEN(XLEN)) u_adder (
        .a   (pc_out),
        .b   (incr),
        .sum (pc_plus_4)
    );

    assign halted = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pc_out    <= RESET_VECTOR;
            trap      <= 1'b0;
            trap_addr <= '0;
            retired   <= '0;
        end else begin
            // trap is a single-cycle pulse regardless of what follows
            trap <= 1'b0;
            case (state)
                RUN: begin
                    if (!stall) begin
                        if (ebreak) begin
                            state   <= HALT;
                            retired <= retired + CNT_W'(1);
                        end else if (pc_src && misaligned) begin
                            pc_out    <= TRAP_VECTOR;
                            trap_addr <= pc_target;
                            trap      <= 1'b1;
                        end else if (pc_src) begin
                            pc_out  <= pc_target;
                            retired <= retired + CNT_W'(1);
                        end else begin
                            pc_out  <= pc_plus_4;
                            retired <= retired + CNT_W'(1);
                        end
                    end
                end
                HALT: begin
                    // step past the EBREAK; it already retired when it halted us
                    if (resume) begin
                        pc_out <= pc_plus_4;
                        state  <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expectations.
// Compressed-instruction steps are active when PC_RVC_EN is defined.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, pc_src, ebreak, resume;
    logic [31:0] pc_target;
`ifdef PC_RVC_EN
    logic        is_compressed;
`endif
    logic [31:0] pc_out, pc_plus_4, trap_addr, retired;
    logic        halted, trap;

    int checks   = 0;
    int failures = 0;

    pc_gen dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pc_src        (pc_src),
        .pc_target     (pc_target),
        .ebreak        (ebreak),
        .resume        (resume),
`ifdef PC_RVC_EN
        .is_compressed (is_compressed),
`endif
        .pc_out        (pc_out),
        .pc_plus_4     (pc_plus_4),
        .halted        (halted),
        .trap          (trap),
        .trap_addr     (trap_addr),
        .retired       (retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic state_chk(input string tag, input logic [31:0] pc, input logic [31:0] ret,
                             input logic hlt, input logic trp);
        chk({tag, ".pc"},      pc_out, pc);
        chk({tag, ".retired"}, retired, ret);
        chk({tag, ".halted"},  {31'd0, halted}, {31'd0, hlt});
        chk({tag, ".trap"},    {31'd0, trap}, {31'd0, trp});
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 0; pc_src = 0; ebreak = 0; resume = 0; pc_target = '0;
`ifdef PC_RVC_EN
        is_compressed = 0;
`endif
        #12;
        state_chk("reset", 32'h0, 32'd0, 1'b0, 1'b0);
        chk("reset.trap_addr", trap_addr, 32'h0);
        chk("reset.pc_plus_4", pc_plus_4, 32'h4);
        rst = 1'b0;

        // sequential fetch
        tick(); tick(); tick();
        state_chk("idle3", 32'hC, 32'd3, 1'b0, 1'b0);

        // aligned branch and stalled branch
        pc_src = 1; pc_target = 32'h40;
        tick();
        state_chk("branch", 32'h40, 32'd4, 1'b0, 1'b0);
        chk("branch.pc_plus_4", pc_plus_4, 32'h44);
        stall = 1; pc_target = 32'h80;
        tick();
        state_chk("stall", 32'h40, 32'd4, 1'b0, 1'b0);
        stall = 0;

`ifdef PC_RVC_EN
        pc_target = 32'h10;
        tick();
        state_chk("rvc.to10", 32'h10, 32'd5, 1'b0, 1'b0);
        pc_src = 0; is_compressed = 1; #1;
        chk("rvc.pc_plus_2", pc_plus_4, 32'h12);
        tick();
        state_chk("rvc.seq", 32'h12, 32'd6, 1'b0, 1'b0);
        is_compressed = 0; pc_src = 1; pc_target = 32'h42;
        tick();
        state_chk("rvc.half_ok", 32'h42, 32'd7, 1'b0, 1'b0);
        pc_target = 32'h43;
        tick();
        state_chk("rvc.odd_trap", 32'h100, 32'd7, 1'b0, 1'b1);
        chk("rvc.trap_addr", trap_addr, 32'h43);
`else
        pc_target = 32'h42;
        tick();
        state_chk("mis42", 32'h100, 32'd4, 1'b0, 1'b1);
        chk("mis42.trap_addr", trap_addr, 32'h42);
        pc_src = 0;
        tick();
        state_chk("mis42.after", 32'h104, 32'd5, 1'b0, 1'b0);
`endif
        pc_src = 0;
        pulse_reset();
        state_chk("reset2", 32'h0, 32'd0, 1'b0, 1'b0);

        // odd target traps in every build; trap drops even under stall
        pc_src = 1; pc_target = 32'h103;
        tick();
        state_chk("mis103", 32'h100, 32'd0, 1'b0, 1'b1);
        chk("mis103.trap_addr", trap_addr, 32'h103);
        pc_src = 0; stall = 1;
        tick();
        state_chk("trap_stall", 32'h100, 32'd0, 1'b0, 1'b0);
        stall = 0;
        tick();
        state_chk("post_trap", 32'h104, 32'd1, 1'b0, 1'b0);

        // halt at 0x20, ignore everything but resume
        pc_src = 1; pc_target = 32'h20;
        tick();
        state_chk("to20", 32'h20, 32'd2, 1'b0, 1'b0);
        pc_src = 0; ebreak = 1;
        tick();
        state_chk("ebreak", 32'h20, 32'd3, 1'b1, 1'b0);
        pc_src = 1; pc_target = 32'h81;
        for (int i = 0; i < 5; i++) begin
            stall = i[0];
            tick();
            state_chk("halted_hold", 32'h20, 32'd3, 1'b1, 1'b0);
        end
        pc_src = 0; ebreak = 0; stall = 0; resume = 1;
        tick();
        state_chk("resume", 32'h24, 32'd3, 1'b0, 1'b0);
        tick();
        state_chk("resume_in_run", 32'h28, 32'd4, 1'b0, 1'b0);
        resume = 0;

        // address wrap
        pc_src = 1; pc_target = 32'hFFFF_FFFC;
        tick();
        state_chk("top", 32'hFFFF_FFFC, 32'd5, 1'b0, 1'b0);
        chk("top.pc_plus_4", pc_plus_4, 32'h0);
        pc_src = 0;
        tick();
        state_chk("wrap", 32'h0, 32'd6, 1'b0, 1'b0);
        tick();
        state_chk("wrap+4", 32'h4, 32'd7, 1'b0, 1'b0);

        // async reset while halted, no clock edge in between
        ebreak = 1;
        tick();
        state_chk("halt2", 32'h4, 32'd8, 1'b1, 1'b0);
        ebreak = 0;
        #2 rst = 1'b1;
        #1;
        state_chk("async_rst", 32'h0, 32'd0, 1'b0, 1'b0);
        #2 rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
